// File: rtl/vliw_hazard_scoreboard_if.sv
// ID-stage bundle bus for the VLIW hazard scoreboard: decoded bundle and
// pipeline controls in, stall/enable controls and the stall counter out.
interface vliw_hazard_scoreboard_if #(
   parameter int SLOTS = 2,
   parameter int REGW  = 5,
   parameter int CNTW  = 32
);
   logic [SLOTS-1:0]        id_valid;
   logic [SLOTS*3*REGW-1:0] id_src;
   logic [SLOTS*3-1:0]      id_src_used;
   logic [SLOTS*REGW-1:0]   id_dest;
   logic [SLOTS-1:0]        id_regwrite;
   logic [SLOTS-1:0]        id_memread;
   logic [SLOTS-1:0]        id_branch;
   logic                    ext_stall;
   logic                    flush;
   logic                    pc_write;
   logic                    if_id_write;
   logic                    id_ex_bubble;
   logic [CNTW-1:0]         stall_cycles;

   // No valid/ready pair here: the bundle is presented by ID every cycle and
   // is consumed (issued) in a cycle where pc_write=1 and id_ex_bubble=0.
   modport master (
      output id_valid, id_src, id_src_used, id_dest, id_regwrite,
             id_memread, id_branch, ext_stall, flush,
      input  pc_write, if_id_write, id_ex_bubble, stall_cycles
   );

   modport slave (
      input  id_valid, id_src, id_src_used, id_dest, id_regwrite,
             id_memread, id_branch, ext_stall, flush,
      output pc_write, if_id_write, id_ex_bubble, stall_cycles
   );
endinterface

// File: rtl/vliw_hazard_scoreboard.sv
// Per-register countdown scoreboard deciding load-use / branch-operand stalls
// for an N-slot VLIW bundle in ID, plus a saturating stall-cycle counter.
module vliw_hazard_scoreboard #(
   parameter int SLOTS    = 2,
   parameter int NREG     = 32,
   parameter int REGW     = 5,
   parameter int LOAD_USE = 1,
   parameter int BR_EXTRA = 1,
   parameter int CNTW     = 32
) (
   input logic                    clk,
   input logic                    reset,
   vliw_hazard_scoreboard_if.slave bus
);
   localparam int CMAX = BR_EXTRA + LOAD_USE;
   localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX + 1);
   localparam logic [CW-1:0] LAT_ALU  = CW'(BR_EXTRA);
   localparam logic [CW-1:0] LAT_LOAD = CW'(CMAX);
   localparam logic [CW-1:0] THR_NORM = CW'(BR_EXTRA);

   logic [CW-1:0]   cnt_q [NREG];
   logic [CW-1:0]   cnt_d [NREG];
   logic [CNTW-1:0] stall_cycles_q;
   logic [CNTW-1:0] stall_cycles_d;

   logic            hazard;
   logic            stall_raise;
   logic            issue;
   logic [REGW-1:0] src_idx;
   logic [REGW-1:0] dest_idx;
   logic [CW-1:0]   lat;
   logic [NREG-1:0] claimed;

   // Readiness uses only the registered counts, so slots of one bundle never
   // see each other's writes.
   always_comb begin
      hazard  = 1'b0;
      src_idx = '0;
      for (int s = 0; s < SLOTS; s++) begin
         for (int k = 0; k < 3; k++) begin
            src_idx = bus.id_src[(s*3+k)*REGW +: REGW];
            if (bus.id_valid[s] && bus.id_src_used[s*3+k] &&
                src_idx != '0 && int'(src_idx) < NREG) begin
               if (bus.id_branch[s]) begin
                  if (cnt_q[src_idx] != '0) hazard = 1'b1;
               end else begin
                  if (cnt_q[src_idx] > THR_NORM) hazard = 1'b1;
               end
            end
         end
      end
   end

   assign stall_raise = hazard & ~bus.flush;
   assign issue       = (|bus.id_valid) & ~hazard & ~bus.ext_stall & ~bus.flush;

   assign bus.id_ex_bubble = stall_raise;
   assign bus.pc_write     = ~stall_raise & ~bus.ext_stall;
   assign bus.if_id_write  = ~stall_raise & ~bus.ext_stall;
   assign bus.stall_cycles = stall_cycles_q;

   // A new producer overrides the decrement; when two slots hit the same
   // destination the longer latency is kept.
   always_comb begin
      claimed  = '0;
      dest_idx = '0;
      lat      = '0;
      for (int r = 0; r < NREG; r++) cnt_d[r] = cnt_q[r];
      if (!bus.ext_stall) begin
         for (int r = 1; r < NREG; r++) begin
            if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - 1'b1;
         end
         if (issue) begin
            for (int s = 0; s < SLOTS; s++) begin
               dest_idx = bus.id_dest[s*REGW +: REGW];
               lat      = bus.id_memread[s] ? LAT_LOAD : LAT_ALU;
               if (bus.id_valid[s] && bus.id_regwrite[s] &&
                   dest_idx != '0 && int'(dest_idx) < NREG) begin
                  if (!claimed[dest_idx] || lat > cnt_d[dest_idx]) cnt_d[dest_idx] = lat;
                  claimed[dest_idx] = 1'b1;
               end
            end
         end
      end
      cnt_d[0] = '0;
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall_raise && !bus.ext_stall && stall_cycles_q != {CNTW{1'b1}})
         stall_cycles_d = stall_cycles_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
         stall_cycles_q <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
         stall_cycles_q <= stall_cycles_d;
      end
   end
endmodule

// File: tb/tb_vliw_hazard_scoreboard.sv
// Self-checking bench for vliw_hazard_scoreboard: directed stall scenarios plus
// randomized bundles checked against a timestamp-based readiness model.
module tb_vliw_hazard_scoreboard;
   localparam int SLOTS    = 2;
   localparam int NREG     = 32;
   localparam int REGW     = 5;
   localparam int LOAD_USE = 1;
   localparam int BR_EXTRA = 1;
   localparam int CNTW     = 32;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   vliw_hazard_scoreboard_if #(.SLOTS(SLOTS), .REGW(REGW), .CNTW(CNTW)) bus ();

   vliw_hazard_scoreboard #(
      .SLOTS(SLOTS), .NREG(NREG), .REGW(REGW),
      .LOAD_USE(LOAD_USE), .BR_EXTRA(BR_EXTRA), .CNTW(CNTW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // avail[r] is the active-cycle time at which register r has no pending
   // latency left; active time only advances on edges without ext_stall.
   int              now_t;
   int              avail [NREG];
   logic [CNTW-1:0] m_stall;
   logic [CNTW-1:0] exp_q [$];

   task automatic m_reset();
      now_t   = 0;
      m_stall = '0;
      for (int r = 0; r < NREG; r++) avail[r] = 0;
   endtask

   function automatic int rem_of(input int r);
      int x;
      if (r == 0) return 0;
      x = avail[r] - now_t;
      return (x < 0) ? 0 : x;
   endfunction

   function automatic bit m_hazard();
      int r;
      bit hz;
      hz = 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
         if (bus.id_valid[s]) begin
            for (int k = 0; k < 3; k++) begin
               r = int'(bus.id_src[(s*3+k)*REGW +: REGW]);
               if (bus.id_src_used[s*3+k]) begin
                  if (bus.id_branch[s] && rem_of(r) > 0) hz = 1'b1;
                  if (!bus.id_branch[s] && rem_of(r) > BR_EXTRA) hz = 1'b1;
               end
            end
         end
      end
      return hz;
   endfunction

   task automatic m_edge();
      bit hz;
      int lat_b [NREG];
      int d;
      int l;
      if (bus.ext_stall) return;
      hz = m_hazard();
      if (hz && !bus.flush && m_stall != {CNTW{1'b1}}) m_stall = m_stall + 1;
      if ((|bus.id_valid) && !hz && !bus.flush) begin
         for (int r = 0; r < NREG; r++) lat_b[r] = -1;
         for (int s = 0; s < SLOTS; s++) begin
            d = int'(bus.id_dest[s*REGW +: REGW]);
            l = bus.id_memread[s] ? (BR_EXTRA + LOAD_USE) : BR_EXTRA;
            if (bus.id_valid[s] && bus.id_regwrite[s] && d != 0 && l > lat_b[d]) lat_b[d] = l;
         end
         for (int r = 1; r < NREG; r++)
            if (lat_b[r] >= 0) avail[r] = now_t + 1 + lat_b[r];
      end
      now_t = now_t + 1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_bundle();
      bus.id_valid    = '0;
      bus.id_src      = '0;
      bus.id_src_used = '0;
      bus.id_dest     = '0;
      bus.id_regwrite = '0;
      bus.id_memread  = '0;
      bus.id_branch   = '0;
      bus.ext_stall   = 1'b0;
      bus.flush       = 1'b0;
   endtask

   task automatic set_slot(input int s, input bit v, input int dest, input bit rw,
                           input bit mr, input bit br, input int s0, input int s1,
                           input int s2, input logic [2:0] used);
      bus.id_valid[s]                 = v;
      bus.id_dest[s*REGW +: REGW]     = REGW'(dest);
      bus.id_regwrite[s]              = rw;
      bus.id_memread[s]               = mr;
      bus.id_branch[s]                = br;
      bus.id_src[(s*3+0)*REGW +: REGW] = REGW'(s0);
      bus.id_src[(s*3+1)*REGW +: REGW] = REGW'(s1);
      bus.id_src[(s*3+2)*REGW +: REGW] = REGW'(s2);
      bus.id_src_used[s*3 +: 3]       = used;
   endtask

   task automatic dut_reset();
      clear_bundle();
      reset = 1'b1;
      m_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic step();
      m_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Holds the current bundle in ID until it issues; reports bubble count.
   task automatic hold_bundle(output int bubbles, output bit timed_out);
      bubbles   = 0;
      timed_out = 1'b1;
      for (int i = 0; i < 16; i++) begin
         #1;
         if (bus.id_ex_bubble) bubbles++;
         if (bus.pc_write) begin
            step();
            timed_out = 1'b0;
            break;
         end
         step();
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int b;
      bit to;
      dut_reset();
      set_slot(0, 1, 5, 1, 1, 0, 0, 0, 0, 3'b000);
      step();
      clear_bundle();
      set_slot(1, 1, 6, 1, 0, 1, 5, 0, 0, 3'b001);
      step();
      #1;
      reset = 1'b1;
      m_reset();
      #1;
      n_checks++;
      if (bus.stall_cycles !== '0) begin
         n_fail++; $display("FAIL reset_stall_cycles got=%0d exp=0", bus.stall_cycles);
      end
      n_checks++;
      if (bus.pc_write !== 1'b1 || bus.if_id_write !== 1'b1) begin
         n_fail++; $display("FAIL reset_enables got pc=%b ifid=%b exp=1/1", bus.pc_write, bus.if_id_write);
      end
      n_checks++;
      if (bus.id_ex_bubble !== 1'b0) begin
         n_fail++; $display("FAIL reset_bubble got=%b exp=0", bus.id_ex_bubble);
      end
      @(negedge clk);
      reset = 1'b0;
      hold_bundle(b, to);
      n_checks++;
      if (to || b !== 0) begin
         n_fail++; $display("FAIL reset_cnt_cleared got bubbles=%0d timeout=%b exp=0", b, to);
      end
   endtask

   task automatic test_load_use();
      int b;
      bit to;
      dut_reset();
      set_slot(0, 1, 5, 1, 1, 0, 0, 0, 0, 3'b000);
      step();
      clear_bundle();
      set_slot(0, 1, 8, 1, 0, 0, 1, 2, 0, 3'b011);
      set_slot(1, 1, 9, 1, 0, 0, 5, 4, 0, 3'b011);
      hold_bundle(b, to);
      n_checks++;
      if (to || b !== 1) begin
         n_fail++; $display("FAIL load_use_bubbles got=%0d timeout=%b exp=1", b, to);
      end
      n_checks++;
      if (bus.stall_cycles !== 32'd1) begin
         n_fail++; $display("FAIL load_use_stall_cycles got=%0d exp=1", bus.stall_cycles);
      end
   endtask

   task automatic test_branch();
      int b;
      bit to;
      dut_reset();
      set_slot(0, 1, 7, 1, 1, 0, 0, 0, 0, 3'b000);
      step();
      clear_bundle();
      set_slot(0, 1, 0, 0, 0, 1, 7, 1, 0, 3'b011);
      hold_bundle(b, to);
      n_checks++;
      if (to || b !== 2) begin
         n_fail++; $display("FAIL load_branch_bubbles got=%0d timeout=%b exp=2", b, to);
      end
      clear_bundle();
      set_slot(1, 1, 7, 1, 0, 0, 1, 2, 0, 3'b011);
      step();
      clear_bundle();
      set_slot(0, 1, 0, 0, 0, 1, 7, 0, 0, 3'b001);
      hold_bundle(b, to);
      n_checks++;
      if (to || b !== 1) begin
         n_fail++; $display("FAIL alu_branch_bubbles got=%0d timeout=%b exp=1", b, to);
      end
      n_checks++;
      if (bus.stall_cycles !== 32'd3) begin
         n_fail++; $display("FAIL branch_stall_cycles got=%0d exp=3", bus.stall_cycles);
      end
   endtask

   task automatic test_same_dest();
      int b;
      bit to;
      dut_reset();
      set_slot(0, 1, 3, 1, 1, 0, 0, 0, 0, 3'b000);
      set_slot(1, 1, 3, 1, 0, 0, 1, 0, 0, 3'b001);
      step();
      clear_bundle();
      set_slot(1, 1, 0, 0, 0, 1, 3, 0, 0, 3'b001);
      hold_bundle(b, to);
      n_checks++;
      if (to || b !== 2) begin
         n_fail++; $display("FAIL same_dest_bubbles got=%0d timeout=%b exp=2", b, to);
      end
      clear_bundle();
      set_slot(0, 1, 0, 1, 1, 0, 0, 0, 0, 3'b000);
      step();
      clear_bundle();
      set_slot(0, 1, 0, 0, 0, 1, 0, 0, 0, 3'b111);
      hold_bundle(b, to);
      n_checks++;
      if (to || b !== 0) begin
         n_fail++; $display("FAIL r0_bubbles got=%0d timeout=%b exp=0", b, to);
      end
      clear_bundle();
      set_slot(0, 1, 4, 1, 1, 0, 0, 0, 0, 3'b000);
      set_slot(1, 1, 0, 0, 0, 1, 4, 0, 0, 3'b001);
      hold_bundle(b, to);
      n_checks++;
      if (to || b !== 0) begin
         n_fail++; $display("FAIL intra_bundle_bubbles got=%0d timeout=%b exp=0", b, to);
      end
   endtask

   task automatic test_ext_stall();
      int b;
      bit to;
      dut_reset();
      set_slot(0, 1, 9, 1, 1, 0, 0, 0, 0, 3'b000);
      step();
      clear_bundle();
      set_slot(0, 1, 10, 1, 0, 0, 9, 0, 0, 3'b001);
      bus.ext_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (bus.pc_write !== 1'b0 || bus.if_id_write !== 1'b0) begin
            n_fail++; $display("FAIL ext_stall_enables cyc=%0d got pc=%b ifid=%b exp=0/0", i, bus.pc_write, bus.if_id_write);
         end
         step();
         n_checks++;
         if (bus.stall_cycles !== 32'd0) begin
            n_fail++; $display("FAIL ext_stall_counter cyc=%0d got=%0d exp=0", i, bus.stall_cycles);
         end
      end
      bus.ext_stall = 1'b0;
      hold_bundle(b, to);
      n_checks++;
      if (to || b !== 1) begin
         n_fail++; $display("FAIL ext_stall_release_bubbles got=%0d timeout=%b exp=1", b, to);
      end
      n_checks++;
      if (bus.stall_cycles !== 32'd1) begin
         n_fail++; $display("FAIL ext_stall_release_count got=%0d exp=1", bus.stall_cycles);
      end
   endtask

   task automatic test_flush();
      int b;
      bit to;
      dut_reset();
      set_slot(0, 1, 5, 1, 1, 0, 0, 0, 0, 3'b000);
      step();
      clear_bundle();
      set_slot(1, 1, 6, 1, 0, 0, 5, 0, 0, 3'b001);
      bus.flush = 1'b1;
      #1;
      n_checks++;
      if (bus.id_ex_bubble !== 1'b0 || bus.pc_write !== 1'b1) begin
         n_fail++; $display("FAIL flush_outputs got bubble=%b pc=%b exp=0/1", bus.id_ex_bubble, bus.pc_write);
      end
      step();
      n_checks++;
      if (bus.stall_cycles !== 32'd0) begin
         n_fail++; $display("FAIL flush_counter got=%0d exp=0", bus.stall_cycles);
      end
      clear_bundle();
      set_slot(0, 1, 12, 1, 1, 0, 0, 0, 0, 3'b000);
      bus.flush = 1'b1;
      step();
      clear_bundle();
      set_slot(0, 1, 0, 0, 0, 1, 12, 0, 0, 3'b001);
      hold_bundle(b, to);
      n_checks++;
      if (to || b !== 0) begin
         n_fail++; $display("FAIL flush_no_issue got bubbles=%0d timeout=%b exp=0", b, to);
      end
   endtask

   task automatic test_reset_mid();
      dut_reset();
      set_slot(0, 1, 7, 1, 1, 0, 0, 0, 0, 3'b000);
      step();
      clear_bundle();
      set_slot(0, 1, 0, 0, 0, 1, 7, 0, 0, 3'b001);
      #1;
      n_checks++;
      if (bus.id_ex_bubble !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid_pre_bubble got=%b exp=1", bus.id_ex_bubble);
      end
      step();
      reset = 1'b1;
      m_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (bus.id_ex_bubble !== 1'b0 || bus.pc_write !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid_issue got bubble=%b pc=%b exp=0/1", bus.id_ex_bubble, bus.pc_write);
      end
      step();
   endtask

   task automatic test_random();
      logic            exp_bub;
      logic            exp_pc;
      logic [CNTW-1:0] exp_cnt;
      dut_reset();
      exp_q.delete();
      for (int c = 0; c < 400; c++) begin
         clear_bundle();
         for (int s = 0; s < SLOTS; s++)
            set_slot(s, ($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 1),
                     $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                     $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                     3'($urandom_range(0, 7)));
         bus.ext_stall = ($urandom_range(0, 7) == 0);
         bus.flush     = ($urandom_range(0, 7) == 0);
         #1;
         exp_bub = m_hazard() & ~bus.flush;
         exp_pc  = ~exp_bub & ~bus.ext_stall;
         n_checks++;
         if (bus.id_ex_bubble !== exp_bub) begin
            n_fail++; $display("FAIL rand_bubble cyc=%0d got=%b exp=%b", c, bus.id_ex_bubble, exp_bub);
         end
         n_checks++;
         if (bus.pc_write !== exp_pc || bus.if_id_write !== exp_pc) begin
            n_fail++; $display("FAIL rand_enables cyc=%0d got pc=%b ifid=%b exp=%b", c, bus.pc_write, bus.if_id_write, exp_pc);
         end
         m_edge();
         exp_q.push_back(m_stall);
         @(posedge clk);
         @(negedge clk);
         exp_cnt = exp_q.pop_front();
         n_checks++;
         if (bus.stall_cycles !== exp_cnt) begin
            n_fail++; $display("FAIL rand_stall_cycles cyc=%0d got=%0d exp=%0d", c, bus.stall_cycles, exp_cnt);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      clear_bundle();
      m_reset();
      test_reset();
      test_load_use();
      test_branch();
      test_same_dest();
      test_ext_stall();
      test_flush();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
